// File: rtl/ifu_if.sv
// Fetch-side bus bundle: pmem instruction port, IDU handshake, redirect/halt control.
// Latency: wires only.
// Backpressure: ready_idu_i from IDU stalls the fetch FIFO.
interface ifu_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] instr_addr_pmem_o;
    logic [DATA_WIDTH-1:0] instr_pmem_i;
    logic                  valid_idu_o;
    logic                  ready_idu_i;
    logic [DATA_WIDTH-1:0] instr_idu_o;
    logic [ADDR_WIDTH-1:0] pc_idu_o;
    logic                  fault_idu_o;
    logic                  redirect_valid_i;
    logic [ADDR_WIDTH-1:0] redirect_pc_i;
    logic                  halt_i;
    logic                  halted_o;
    logic [31:0]           fetch_cnt_o;

    // IFU side
    modport master (
        output instr_addr_pmem_o, valid_idu_o, instr_idu_o, pc_idu_o,
               fault_idu_o, halted_o, fetch_cnt_o,
        input  instr_pmem_i, ready_idu_i, redirect_valid_i, redirect_pc_i, halt_i
    );

    // Environment side (pmem + IDU + execute)
    modport slave (
        input  instr_addr_pmem_o, valid_idu_o, instr_idu_o, pc_idu_o,
               fault_idu_o, halted_o, fetch_cnt_o,
        output instr_pmem_i, ready_idu_i, redirect_valid_i, redirect_pc_i, halt_i
    );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: PC, combinational pmem read, 2-entry in-order fetch FIFO to IDU.
// Latency: fetched word is at the IDU head 1 cycle after its push edge; 1 instr/cycle sustained.
// Backpressure: ready_idu_i low lets the FIFO fill to 2, then the PC stalls until a pop.
module ifu #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = 32'h8000_0000
) (
    input  logic     clk,
    input  logic     rst_n,
    ifu_if.master    bus
);
    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0] pc;
        logic                  fault;
    } entry_t;

    typedef enum logic [0:0] {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [31:0]           fetch_cnt;
    logic [1:0]            count;
    entry_t                head;
    entry_t                tail;

    logic   pop;
    logic   redirect;
    logic   push;
    logic   misaligned;
    entry_t new_entry;

    assign misaligned = (pc[1:0] != 2'b00);
    assign pop        = (count != 2'd0) && bus.ready_idu_i;
    // Redirect and halt only count while running; in HALT the PC is frozen.
    assign redirect   = (state == RUN) && bus.redirect_valid_i;
    assign push       = (state == RUN) && !bus.redirect_valid_i && !bus.halt_i &&
                        ((count != 2'd2) || pop);
    assign new_entry  = '{instr: bus.instr_pmem_i, pc: pc, fault: misaligned};

    // Control: run/halt FSM, program counter and push counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            pc        <= MEM_BASE;
            fetch_cnt <= 32'd0;
        end else begin
            if (redirect) begin
                pc <= bus.redirect_pc_i;
            end else if (push) begin
                pc        <= pc + ADDR_WIDTH'(4);
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            // A faulting push is the last one; halt stays until reset.
            if (state == RUN && (bus.halt_i || (push && misaligned))) begin
                state <= HALT;
            end
        end
    end

    // FIFO storage: head is the registered IDU output, tail is the second slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else if (redirect) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= new_entry;
                    end else begin
                        head <= tail;
                        tail <= new_entry;
                    end
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b10: begin
                    if (count == 2'd0) begin
                        head <= new_entry;
                    end else begin
                        tail <= new_entry;
                    end
                    count <= count + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.instr_addr_pmem_o = pc;
    assign bus.valid_idu_o       = (count != 2'd0);
    assign bus.instr_idu_o       = head.instr;
    assign bus.pc_idu_o          = head.pc;
    assign bus.fault_idu_o       = head.fault;
    assign bus.halted_o          = (state == HALT) && (count == 2'd0);
    assign bus.fetch_cnt_o       = fetch_cnt;
endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit: owns the program counter, drives the combinational instruction-read port of `pmem`, and buffers fetched words in a 2-entry FIFO that feeds the decode stage (IDU) over a valid/ready handshake. It sits directly upstream of `pmem`'s instruction port and directly upstream of the IDU. It also accepts PC redirects from execute and a halt request.

## Interface
- `ADDR_WIDTH`, 32, address / PC width
- `DATA_WIDTH`, 32, instruction width
- `MEM_BASE`, 32'h8000_0000, reset PC; first fetch address
- `clk` in 1, single clock; all state updates on posedge
- `rst_n` in 1, reset, asynchronous, active-low
- `instr_addr_pmem_o` out ADDR_WIDTH, fetch address to `pmem`; always equals the PC register
- `instr_pmem_i` in DATA_WIDTH, instruction word from `pmem`; valid combinationally in the same cycle as the address
- `valid_idu_o` out 1, FIFO head valid
- `ready_idu_i` in 1, IDU accepts the head this cycle
- `instr_idu_o` out DATA_WIDTH, head instruction
- `pc_idu_o` out ADDR_WIDTH, head PC
- `fault_idu_o` out 1, head was fetched from a misaligned PC (`pc[1:0] != 0`)
- `redirect_valid_i` in 1, execute requests a PC change
- `redirect_pc_i` in ADDR_WIDTH, target PC
- `halt_i` in 1, stop fetching (ebreak / simulation end)
- `halted_o` out 1, state is HALT and FIFO is empty
- `fetch_cnt_o` out 32, number of entries pushed since reset; wraps modulo 2^32

## Operation
- State machine: RUN and HALT. Reset enters RUN. RUN→HALT on `halt_i`, or on a push of a misaligned entry. HALT is sticky until reset.
- Pop: `valid_idu_o && ready_idu_i`.
- Fetch/push, RUN only: occurs when there is no redirect and (count < 2 or pop this cycle). It captures `{instr_pmem_i, pc, misaligned}` into the FIFO tail, sets pc ← pc + 4 (modulo 2^ADDR_WIDTH, carry discarded), and increments `fetch_cnt_o`.
- Redirect (RUN only; ignored in HALT):
  - FIFO is flushed (count ← 0, including any entry being popped that cycle).
  - pc ← `redirect_pc_i`.
  - No push that cycle.
  - Redirect has priority over fetch.
- Halt:
  - `halt_i` in RUN blocks the push in that same cycle.
  - FIFO is not flushed; it drains normally through the IDU.
  - `halt_i` together with `redirect_valid_i`: both the flush and the pc update happen, and the state becomes HALT.
- Misaligned PC:
  - The address is still driven unmodified.
  - The entry is pushed with fault = 1.
  - The FIFO is not flushed.
  - No further pushes occur.
- FIFO:
  - Two entries, in-order, with registered outputs.
  - Pop and push in the same cycle when full is legal; count is unchanged.
  - Push when full without a pop never occurs.
  - Payload outputs are don't-care when `valid_idu_o` = 0.

## Timing
- Reset values:
  - pc and `instr_addr_pmem_o` = MEM_BASE
  - count = 0, so `valid_idu_o` = 0
  - `instr_idu_o`, `pc_idu_o` = 0
  - `fault_idu_o` = 0
  - `halted_o` = 0
  - `fetch_cnt_o` = 0
  - state = RUN
- Reset mid-operation clears all state immediately (asynchronous); there is no partial drain.
- First edge after `rst_n` rises pushes MEM_BASE. `valid_idu_o` = 1 in the following cycle, with `pc_idu_o` = MEM_BASE.
- Fetch-to-IDU latency: 1 cycle. Sustained throughput: 1 instruction per cycle while `ready_idu_i` = 1.
- With `ready_idu_i` held low, the FIFO fills after 2 pushes and pc stalls at the third address.
- Redirect at edge N: `valid_idu_o` = 0 in cycle N+1 and the address equals the target. The first target entry is valid in cycle N+2.
- `halted_o` rises the cycle after the last entry pops in HALT, or the cycle after entering HALT with an empty FIFO.

## Test plan
- Reset release, `ready_idu_i` = 1, memory returns addr^1 → heads with pcs 8000_0000, 8000_0004, 8000_0008 on consecutive cycles; `fetch_cnt_o` increments by 1 per cycle.
- `ready_idu_i` = 0 for 5 cycles after reset → `instr_addr_pmem_o` = 8000_0008, count = 2, `fetch_cnt_o` = 2. Raise ready → 8000_0000 and 8000_0004 pop in order, with no loss or duplication.
- Full FIFO plus redirect to 8000_0100 while a pop occurs → `valid_idu_o` = 0 next cycle. The following head is pc 8000_0100; no stale entries appear.
- Redirect to 8000_0102 → one entry with `fault_idu_o` = 1 and pc 8000_0102. No further pushes; `halted_o` = 1 the cycle after it pops.
- `halt_i` pulsed with 1 entry buffered and ready = 1 → that entry pops, `halted_o` = 1, `fetch_cnt_o` is frozen. A later redirect is ignored (pc unchanged).
- Redirect to FFFF_FFFC, ADDR_WIDTH = 32 → next pc wraps to 0000_0000. Asserting `rst_n` low mid-stream → all outputs return to reset values in the same cycle.
